// File: rtl/power_gate_sequencer.sv
// rtl/power_gate_sequencer.sv - per-domain isolation/sleep sequencer with request filtering and wake arbitration
//
// Purpose:
//   Turns NDOM filtered power-gate requests into ordered isolate -> sleep
//   (power down) and wake -> de-isolate (power up) sequences, one FSM per domain.
//   Only one domain may be waking (PUP or DEISO) at any time.
//
// Optional build macro: PGS_RETENTION_EN (adds ret_o and a SAVE state between ISO and PDN)
//
// Ports:
//   clk_i      in   1     block clock
//   rst_ni     in   1     synchronous active-low reset
//   isg_i      in   NDOM  gate request per domain (1 = power down)
//   pwr_ack_i  in   NDOM  switch status per domain (1 = rail up)
//   iso_o      out  NDOM  isolation enable (1 = outputs clamped)
//   sleep_o    out  NDOM  switch control (1 = switch off)
//   dom_on_o   out  NDOM  domain fully on and de-isolated
//   err_o      out  NDOM  sticky acknowledge-timeout flag
//   busy_o     out  1     any domain in a transitional state
//   ret_o      out  NDOM  retention save/hold (PGS_RETENTION_EN only)

module power_gate_sequencer #(
    parameter int NDOM     = 10,
    parameter int FILT_CYC = 4,
    parameter int ISO_CYC  = 2,
    parameter int ACK_TO   = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NDOM-1:0] isg_i,
    input  logic [NDOM-1:0] pwr_ack_i,
    output logic [NDOM-1:0] iso_o,
    output logic [NDOM-1:0] sleep_o,
    output logic [NDOM-1:0] dom_on_o,
    output logic [NDOM-1:0] err_o,
    output logic            busy_o
`ifdef PGS_RETENTION_EN
    ,
    output logic [NDOM-1:0] ret_o
`endif
);

    typedef enum logic [2:0] {
        ST_ON    = 3'd0,
        ST_ISO   = 3'd1,
        ST_PDN   = 3'd2,
        ST_OFF   = 3'd3,
        ST_PUP   = 3'd4,
        ST_DEISO = 3'd5
`ifdef PGS_RETENTION_EN
        ,
        ST_SAVE  = 3'd6
`endif
    } state_t;

    // Terminal counts; counters compare against N-1 so an N-cycle wait ends on the Nth cycle.
    localparam logic [7:0] FILT_LAST = 8'(FILT_CYC - 1);
    localparam logic [7:0] ISO_LAST  = 8'(ISO_CYC - 1);
    localparam logic [7:0] ACK_LAST  = 8'(ACK_TO - 1);

    state_t          r_state     [NDOM];
    state_t          w_state_nxt [NDOM];
    logic [7:0]      r_tmr       [NDOM];
    logic [7:0]      w_tmr_nxt   [NDOM];
    logic [7:0]      r_fcnt      [NDOM];
    logic [7:0]      w_fcnt_nxt  [NDOM];
    logic [NDOM-1:0] r_freq;
    logic [NDOM-1:0] w_freq_eff;
    logic [NDOM-1:0] w_grant;
    logic            w_wake_busy;
    logic            w_found;

    logic [NDOM-1:0] r_iso, r_sleep, r_dom_on, r_err, r_ret;
    logic [NDOM-1:0] w_iso_nxt, w_sleep_nxt, w_dom_on_nxt, w_err_nxt, w_ret_nxt;
    logic            r_busy, w_busy_nxt;

    // Glitch filter. w_freq_eff is the filtered request as it will be after this
    // edge, so the FSM reacts in the same cycle the change is accepted.
    always_comb begin
        for (int n = 0; n < NDOM; n++) begin
            w_freq_eff[n] = r_freq[n];
            w_fcnt_nxt[n] = 8'd0;
            if (isg_i[n] != r_freq[n]) begin
                if (r_fcnt[n] == FILT_LAST) begin
                    w_freq_eff[n] = isg_i[n];
                end else begin
                    w_fcnt_nxt[n] = r_fcnt[n] + 8'd1;
                end
            end
        end
    end

    // Wake arbitration: single-cycle grant to the lowest-index OFF domain asking
    // to power up, only while no other domain is mid-wake.
    always_comb begin
        w_wake_busy = 1'b0;
        w_found     = 1'b0;
        w_grant     = '0;
        for (int n = 0; n < NDOM; n++) begin
            if (r_state[n] == ST_PUP || r_state[n] == ST_DEISO) begin
                w_wake_busy = 1'b1;
            end
        end
        for (int n = 0; n < NDOM; n++) begin
            if (!w_wake_busy && !w_found && r_state[n] == ST_OFF && !w_freq_eff[n]) begin
                w_grant[n] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    // Next-state and output decode; outputs are registered from the next state.
    always_comb begin
        w_busy_nxt = 1'b0;
        for (int n = 0; n < NDOM; n++) begin
            w_state_nxt[n] = r_state[n];
            w_tmr_nxt[n]   = 8'd0;
            w_err_nxt[n]   = r_err[n];

            case (r_state[n])
                ST_ON: begin
                    if (w_freq_eff[n]) begin
                        w_state_nxt[n] = ST_ISO;
                    end
                end
                ST_ISO: begin
                    w_tmr_nxt[n] = r_tmr[n] + 8'd1;
                    if (r_tmr[n] == ISO_LAST) begin
`ifdef PGS_RETENTION_EN
                        w_state_nxt[n] = ST_SAVE;
`else
                        w_state_nxt[n] = ST_PDN;
`endif
                    end
                end
`ifdef PGS_RETENTION_EN
                ST_SAVE: begin
                    w_state_nxt[n] = ST_PDN;
                end
`endif
                ST_PDN: begin
                    w_tmr_nxt[n] = r_tmr[n] + 8'd1;
                    // A real acknowledge wins over an expiry in the same cycle.
                    if (!pwr_ack_i[n]) begin
                        w_state_nxt[n] = ST_OFF;
                    end else if (r_tmr[n] == ACK_LAST) begin
                        w_err_nxt[n]   = 1'b1;
                        w_state_nxt[n] = ST_OFF;
                    end
                end
                ST_OFF: begin
                    if (!w_freq_eff[n] && w_grant[n]) begin
                        w_state_nxt[n] = ST_PUP;
                    end
                end
                ST_PUP: begin
                    w_tmr_nxt[n] = r_tmr[n] + 8'd1;
                    if (pwr_ack_i[n]) begin
                        w_state_nxt[n] = ST_DEISO;
                    end else if (r_tmr[n] == ACK_LAST) begin
                        w_err_nxt[n]   = 1'b1;
                        w_state_nxt[n] = ST_DEISO;
                    end
                end
                ST_DEISO: begin
                    w_tmr_nxt[n] = r_tmr[n] + 8'd1;
                    if (r_tmr[n] == ISO_LAST) begin
                        w_state_nxt[n] = ST_ON;
                    end
                end
                default: begin
                    w_state_nxt[n] = ST_ON;
                end
            endcase

            // Every state entry starts its timer from zero.
            if (w_state_nxt[n] != r_state[n]) begin
                w_tmr_nxt[n] = 8'd0;
            end

            w_iso_nxt[n]    = (w_state_nxt[n] != ST_ON);
            w_sleep_nxt[n]  = (w_state_nxt[n] == ST_PDN) || (w_state_nxt[n] == ST_OFF);
            w_dom_on_nxt[n] = (w_state_nxt[n] == ST_ON);
`ifdef PGS_RETENTION_EN
            w_ret_nxt[n]    = (w_state_nxt[n] == ST_SAVE) || (w_state_nxt[n] == ST_PDN) ||
                              (w_state_nxt[n] == ST_OFF)  || (w_state_nxt[n] == ST_PUP);
`else
            w_ret_nxt[n]    = 1'b0;
`endif
            if (w_state_nxt[n] != ST_ON && w_state_nxt[n] != ST_OFF) begin
                w_busy_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int n = 0; n < NDOM; n++) begin
                r_state[n] <= ST_ON;
                r_tmr[n]   <= 8'd0;
                r_fcnt[n]  <= 8'd0;
            end
            r_freq   <= '0;
            r_iso    <= '0;
            r_sleep  <= '0;
            r_dom_on <= '1;
            r_err    <= '0;
            r_ret    <= '0;
            r_busy   <= 1'b0;
        end else begin
            for (int n = 0; n < NDOM; n++) begin
                r_state[n] <= w_state_nxt[n];
                r_tmr[n]   <= w_tmr_nxt[n];
                r_fcnt[n]  <= w_fcnt_nxt[n];
            end
            r_freq   <= w_freq_eff;
            r_iso    <= w_iso_nxt;
            r_sleep  <= w_sleep_nxt;
            r_dom_on <= w_dom_on_nxt;
            r_err    <= w_err_nxt;
            r_ret    <= w_ret_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign iso_o    = r_iso;
    assign sleep_o  = r_sleep;
    assign dom_on_o = r_dom_on;
    assign err_o    = r_err;
    assign busy_o   = r_busy;
`ifdef PGS_RETENTION_EN
    assign ret_o    = r_ret;
`else
    // r_ret is constant zero without retention; keep it observed.
    logic w_ret_unused;
    assign w_ret_unused = ^r_ret;
`endif

endmodule

// File: doc/power_gate_sequencer.md
Name: power_gate_sequencer

Overview:
- Sits directly downstream of the sensor-driven gating control stage.
- Consumes its ten per-domain gate requests and turns each into an ordered isolation and sleep sequence for that domain's power switch.
- Filters request glitches and enforces isolate-before-sleep and wake-before-de-isolate ordering.
- Allows only one domain to wake at a time, to limit inrush current.

Parameters:
- NDOM, 10, number of power domains (width of all per-domain vectors).
- FILT_CYC, 4, consecutive stable cycles before a request change is accepted (legal range 1..255).
- ISO_CYC, 2, cycles that isolation is held before sleep is asserted, and before isolation is released after wake.
- ACK_TO, 16, maximum cycles to wait for the switch acknowledge before flagging an error.

Ports:
- clk_i  input  1  block clock.
- rst_ni  input  1  reset; synchronous, active-low.
- isg_i  input  NDOM  gate request per domain; 1 = power down, 0 = power up.
- pwr_ack_i  input  NDOM  switch status per domain; 1 = rail up, 0 = rail down.
- iso_o  output  NDOM  isolation enable per domain; 1 = outputs clamped.
- sleep_o  output  NDOM  switch control per domain; 1 = switch off.
- dom_on_o  output  NDOM  domain fully on and de-isolated.
- err_o  output  NDOM  sticky acknowledge-timeout flag per domain.
- busy_o  output  1  any domain not in ON or OFF.

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - All FSMs go to ON.
  - iso_o=0, sleep_o=0, dom_on_o=all 1, err_o=0, busy_o=0.
  - Filtered requests = 0; all counters cleared.
  - Reset mid-sequence aborts immediately to these values.
- Request filter, per domain:
  - An 8-bit counter counts cycles that isg_i[n] differs from freq[n], and clears on any cycle they match.
  - When the count reaches FILT_CYC, freq[n] takes isg_i[n] and the counter clears.
  - Accepted-change latency is FILT_CYC cycles after the first differing cycle.
- Per-domain FSM, all outputs registered:
  - ON: iso=0, sleep=0, dom_on=1. If freq=1, go to ISO and clear the timer.
  - ISO: iso=1, sleep=0, dom_on=0. After ISO_CYC cycles, go to PDN.
  - PDN: iso=1, sleep=1. Wait for pwr_ack=0, then go to OFF.
  - OFF: iso=1, sleep=1. If freq=0 and the wake grant is held for this domain, go to PUP.
  - PUP: iso=1, sleep=0. Wait for pwr_ack=1, then go to DEISO.
  - DEISO: iso=1, sleep=0. After ISO_CYC cycles, go to ON.
- No abort: a request change seen in ISO, PDN, PUP or DEISO is ignored until the domain reaches OFF or ON.
- Timeout:
  - In PDN or PUP, a timer counts cycles.
  - If the timer reaches ACK_TO without the expected acknowledge, set err_o[n] (sticky until reset) and advance as if the acknowledge had arrived.
  - An acknowledge arriving in the same cycle the timer expires counts as a normal acknowledge; no error.
- Wake arbitration:
  - A grant is issued only when no domain is in PUP or DEISO.
  - The grant goes to the lowest-index domain in OFF with freq=0.
  - A grant lasts exactly one cycle.
- Power-down is not arbitrated; any number of domains may be in ISO or PDN at once, and alongside a wake.
- busy_o is registered: 1 whenever any FSM is in ISO, PDN, PUP or DEISO.

Optional Feature:
- Macro: PGS_RETENTION_EN.
- When defined:
  - Adds output ret_o [NDOM].
  - Adds state SAVE between ISO and PDN: ret=1 for 1 cycle, then PDN.
  - ret_o stays 1 through PDN and OFF.
  - ret_o is released in DEISO on its first cycle.
  - ret_o reset value is 0.
- When undefined: no ret_o port and no SAVE state; ISO goes directly to PDN.

Test Plan:
- isg_i[3] pulses high for 3 cycles, with FILT_CYC=4 -> no state change; iso_o=0, dom_on_o[3] stays 1.
- isg_i[3]=1 held, then pwr_ack_i[3] drops 2 cycles after sleep_o[3] rises:
  - iso_o[3] rises 4 cycles after isg_i[3] rises.
  - sleep_o[3] rises 2 cycles later.
  - The domain is in OFF 2 cycles after sleep_o[3] rises; busy_o then falls to 0.
- Domains 2 and 7 are OFF and both drop their request in the same cycle:
  - Domain 2 enters PUP first.
  - Domain 7's sleep_o falls only after domain 2 reaches ON.
- pwr_ack_i[5] is held at 1 during power-down -> err_o[5]=1 after 16 cycles in PDN; the domain still reaches OFF; err_o[5] stays set until reset.
- rst_ni=0 while domain 1 is in PUP -> next cycle iso_o=0, sleep_o=0, dom_on_o=10'h3FF, err_o=0.
- With PGS_RETENTION_EN defined -> ret_o[4] rises 1 cycle after the 2 ISO cycles, before sleep_o[4], and falls on the first DEISO cycle.
